// File: rtl/pico_axi_rd_arbiter_pkg.sv
// Shared types and helpers for the pico AXI read arbiter.
// The AR state encoding and the port-index width function live here so that the
// top and any future siblings agree on them.
package pico_axi_rd_arbiter_pkg;

    // AR channel sequencing: pick a winner, accept its request, forward it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ISSUE = 2'd2
    } ar_state_e;

    // Outstanding-burst counters are 4 bits wide, enough for a cap of up to 15.
    localparam int unsigned CNT_W = 4;

    // Width of the port-index tag; a single requester still reserves one bit.
    function automatic int unsigned port_bits(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pico_rr_arbiter.sv
// Combinational round-robin arbiter: the search for a requester starts at ptr
// and wraps, so the port just after the previous winner has top priority.
module pico_rr_arbiter #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned PB        = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PB-1:0]        ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PB-1:0]        grant_idx,
    output logic                 any
);

    int unsigned cand;

    // First requester found scanning upward from ptr wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int unsigned off = 0; off < NUM_PORTS; off++) begin
            cand = (32'(ptr) + off) % NUM_PORTS;
            if (!any && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = PB'(cand);
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pico_axi_rd_arbiter.sv
// Shares one AXI read master between NUM_PORTS requesters.
// AR is arbitrated round-robin and tagged with the port index in the upper ID
// bits; R beats are steered back by that tag with zero latency.
// Optional statistics are enabled by defining PICO_AXI_RD_ARB_STATS_EN.
module pico_axi_rd_arbiter
    import pico_axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS        = 2,
    parameter int unsigned C_AXI_ID_WIDTH   = 8,
    parameter int unsigned C_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_AXI_DATA_WIDTH = 256,
    parameter int unsigned MAX_OUTSTANDING  = 4,
    localparam int unsigned PB              = port_bits(NUM_PORTS)
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [NUM_PORTS*C_AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [NUM_PORTS*C_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [NUM_PORTS*8-1:0]                s_axi_arlen,
    input  logic [NUM_PORTS-1:0]                  s_axi_arvalid,
    output logic [NUM_PORTS-1:0]                  s_axi_arready,
    output logic [NUM_PORTS*C_AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [NUM_PORTS*C_AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [NUM_PORTS*2-1:0]                s_axi_rresp,
    output logic [NUM_PORTS-1:0]                  s_axi_rlast,
    output logic [NUM_PORTS-1:0]                  s_axi_rvalid,
    input  logic [NUM_PORTS-1:0]                  s_axi_rready,
    output logic [C_AXI_ID_WIDTH+PB-1:0]          m_axi_arid,
    output logic [C_AXI_ADDR_WIDTH-1:0]           m_axi_araddr,
    output logic [7:0]                            m_axi_arlen,
    output logic                                  m_axi_arvalid,
    input  logic                                  m_axi_arready,
    input  logic [C_AXI_ID_WIDTH+PB-1:0]          m_axi_rid,
    input  logic [C_AXI_DATA_WIDTH-1:0]           m_axi_rdata,
    input  logic [1:0]                            m_axi_rresp,
    input  logic                                  m_axi_rlast,
    input  logic                                  m_axi_rvalid,
    output logic                                  m_axi_rready
`ifdef PICO_AXI_RD_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*32-1:0]               rd_arb_grants,
    output logic                                  rd_arb_bad_rid
`endif
);

    localparam int unsigned IW = C_AXI_ID_WIDTH;
    localparam int unsigned AW = C_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_AXI_DATA_WIDTH;

    ar_state_e              state;
    logic [PB-1:0]          gnt_idx;
    logic [PB-1:0]          rr_ptr;
    logic [CNT_W-1:0]       outstanding [NUM_PORTS];

    logic [NUM_PORTS-1:0]   eligible;
    logic [NUM_PORTS-1:0]   arb_grant;
    logic [PB-1:0]          arb_idx;
    logic                   arb_any;

    logic                   ar_hs;
    logic [PB-1:0]          r_sel;
    logic                   sel_ok;
    logic                   r_done;
    logic [NUM_PORTS-1:0]   cnt_inc;
    logic [NUM_PORTS-1:0]   cnt_dec;

    // A port may compete only while it is below its in-flight burst cap.
    always_comb begin
        eligible = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            eligible[p] = s_axi_arvalid[p] && (outstanding[p] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    pico_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PB        (PB)
    ) u_rr (
        .req       (eligible),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // AR sequencing: register the winner, pulse its arready while capturing the
    // payload, then hold the master request until it is accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            gnt_idx       <= '0;
            rr_ptr        <= '0;
            s_axi_arready <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_arid    <= '0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    s_axi_arready <= '0;
                    if (arb_any) begin
                        gnt_idx       <= arb_idx;
                        s_axi_arready <= arb_grant;
                        state         <= GRANT;
                    end
                end
                GRANT: begin
                    s_axi_arready <= '0;
                    m_axi_arid    <= {gnt_idx, s_axi_arid[32'(gnt_idx)*IW +: IW]};
                    m_axi_araddr  <= s_axi_araddr[32'(gnt_idx)*AW +: AW];
                    m_axi_arlen   <= s_axi_arlen[32'(gnt_idx)*8 +: 8];
                    m_axi_arvalid <= 1'b1;
                    state         <= ISSUE;
                end
                ISSUE: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        rr_ptr        <= (gnt_idx == PB'(NUM_PORTS - 1)) ? '0 : gnt_idx + PB'(1);
                        state         <= IDLE;
                    end
                end
                default: begin
                    s_axi_arready <= '0;
                    m_axi_arvalid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign ar_hs  = (state == ISSUE) && m_axi_arvalid && m_axi_arready;
    assign r_sel  = m_axi_rid[IW +: PB];
    assign sel_ok = (32'(r_sel) < NUM_PORTS);
    assign r_done = m_axi_rvalid && m_axi_rready && m_axi_rlast && sel_ok;

    // R steering: only the tagged port sees valid/last; payload is broadcast
    // with the tag removed. Unknown tags are accepted and discarded.
    always_comb begin
        s_axi_rvalid = '0;
        s_axi_rlast  = '0;
        m_axi_rready = 1'b1;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            s_axi_rid[p*IW +: IW]  = m_axi_rid[IW-1:0];
            s_axi_rdata[p*DW +: DW] = m_axi_rdata;
            s_axi_rresp[p*2 +: 2]  = m_axi_rresp;
        end
        if (sel_ok) begin
            s_axi_rvalid[r_sel] = m_axi_rvalid;
            s_axi_rlast[r_sel]  = m_axi_rlast;
            m_axi_rready        = s_axi_rready[r_sel];
        end
    end

    // Per-port increment/decrement requests, with the underflow guard applied here.
    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            cnt_inc[p] = ar_hs && (gnt_idx == PB'(p));
            cnt_dec[p] = r_done && (r_sel == PB'(p)) && (outstanding[p] != '0);
        end
    end

    // Outstanding-burst counters; simultaneous inc and dec cancel out.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                outstanding[p] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (cnt_inc[p] && !cnt_dec[p] && (outstanding[p] != '1)) begin
                    outstanding[p] <= outstanding[p] + CNT_W'(1);
                end else if (cnt_dec[p] && !cnt_inc[p]) begin
                    outstanding[p] <= outstanding[p] - CNT_W'(1);
                end
            end
        end
    end

`ifdef PICO_AXI_RD_ARB_STATS_EN
    // Wrapping grant counters and a sticky flag for dropped bad-ID beats.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_arb_grants  <= '0;
            rd_arb_bad_rid <= 1'b0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (cnt_inc[p]) begin
                    rd_arb_grants[p*32 +: 32] <= rd_arb_grants[p*32 +: 32] + 32'd1;
                end
            end
            if (m_axi_rvalid && !sel_ok) begin
                rd_arb_bad_rid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pico_axi_rd_arbiter.sv
// Scoreboard bench for pico_axi_rd_arbiter: stimulus pushes expected master AR
// requests and per-port R beats into queues; monitors pop and compare them.
// A second three-port instance exercises tags that map to no port.
module tb_pico_axi_rd_arbiter;

    localparam int unsigned N   = 2;
    localparam int unsigned IW  = 8;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 256;
    localparam int unsigned MO  = 4;
    localparam int unsigned PBW = 1;
    localparam int unsigned MIW = IW + PBW;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [N*IW-1:0]  s_axi_arid;
    logic [N*AW-1:0]  s_axi_araddr;
    logic [N*8-1:0]   s_axi_arlen;
    logic [N-1:0]     s_axi_arvalid;
    logic [N-1:0]     s_axi_arready;
    logic [N*IW-1:0]  s_axi_rid;
    logic [N*DW-1:0]  s_axi_rdata;
    logic [N*2-1:0]   s_axi_rresp;
    logic [N-1:0]     s_axi_rlast;
    logic [N-1:0]     s_axi_rvalid;
    logic [N-1:0]     s_axi_rready;
    logic [MIW-1:0]   m_axi_arid;
    logic [AW-1:0]    m_axi_araddr;
    logic [7:0]       m_axi_arlen;
    logic             m_axi_arvalid;
    logic             m_axi_arready;
    logic [MIW-1:0]   m_axi_rid;
    logic [DW-1:0]    m_axi_rdata;
    logic [1:0]       m_axi_rresp;
    logic             m_axi_rlast;
    logic             m_axi_rvalid;
    logic             m_axi_rready;
`ifdef PICO_AXI_RD_ARB_STATS_EN
    logic [N*32-1:0]  rd_arb_grants;
    logic             rd_arb_bad_rid;
    logic [3*32-1:0]  rd_arb_grants3;
    logic             rd_arb_bad_rid3;
`endif

    // three-port instance signals
    logic [3*IW-1:0]  s3_arid_out;
    logic [3*DW-1:0]  s3_rdata;
    logic [3*2-1:0]   s3_rresp;
    logic [2:0]       s3_rlast;
    logic [2:0]       s3_rvalid;
    logic [2:0]       s3_rready;
    logic [2:0]       s3_arready;
    logic [IW+1:0]    m3_arid;
    logic [AW-1:0]    m3_araddr;
    logic [7:0]       m3_arlen;
    logic             m3_arvalid;
    logic [IW+1:0]    m3_rid;
    logic             m3_rlast;
    logic             m3_rvalid;
    logic             m3_rready;

    pico_axi_rd_arbiter #(
        .NUM_PORTS        (N),
        .C_AXI_ID_WIDTH   (IW),
        .C_AXI_ADDR_WIDTH (AW),
        .C_AXI_DATA_WIDTH (DW),
        .MAX_OUTSTANDING  (MO)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
`ifdef PICO_AXI_RD_ARB_STATS_EN
        ,
        .rd_arb_grants  (rd_arb_grants),
        .rd_arb_bad_rid (rd_arb_bad_rid)
`endif
    );

    pico_axi_rd_arbiter #(
        .NUM_PORTS        (3),
        .C_AXI_ID_WIDTH   (IW),
        .C_AXI_ADDR_WIDTH (AW),
        .C_AXI_DATA_WIDTH (DW),
        .MAX_OUTSTANDING  (MO)
    ) dut3 (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_arid    ('0),
        .s_axi_araddr  ('0),
        .s_axi_arlen   ('0),
        .s_axi_arvalid (3'b000),
        .s_axi_arready (s3_arready),
        .s_axi_rid     (s3_arid_out),
        .s_axi_rdata   (s3_rdata),
        .s_axi_rresp   (s3_rresp),
        .s_axi_rlast   (s3_rlast),
        .s_axi_rvalid  (s3_rvalid),
        .s_axi_rready  (s3_rready),
        .m_axi_arid    (m3_arid),
        .m_axi_araddr  (m3_araddr),
        .m_axi_arlen   (m3_arlen),
        .m_axi_arvalid (m3_arvalid),
        .m_axi_arready (1'b1),
        .m_axi_rid     (m3_rid),
        .m_axi_rdata   ('0),
        .m_axi_rresp   (2'b00),
        .m_axi_rlast   (m3_rlast),
        .m_axi_rvalid  (m3_rvalid),
        .m_axi_rready  (m3_rready)
`ifdef PICO_AXI_RD_ARB_STATS_EN
        ,
        .rd_arb_grants  (rd_arb_grants3),
        .rd_arb_bad_rid (rd_arb_bad_rid3)
`endif
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } req_t;

    typedef struct {
        logic [MIW-1:0] id;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
    } ar_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          last;
    } r_t;

    req_t req_q0[$];
    req_t req_q1[$];
    ar_t  ar_exp[$];
    r_t   r_exp0[$];
    r_t   r_exp1[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got event-missing expected event", name);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic push_req(input int unsigned port, input logic [IW-1:0] id,
                            input logic [AW-1:0] addr, input logic [7:0] len, input logic expect_issue);
        req_t r;
        ar_t  a;
        r.id = id; r.addr = addr; r.len = len;
        if (port == 0) req_q0.push_back(r); else req_q1.push_back(r);
        if (expect_issue) begin
            a.id = {PBW'(port), id}; a.addr = addr; a.len = len;
            ar_exp.push_back(a);
        end
    endtask

    // Requester model: presents the head of each port queue, pops on handshake.
    always begin : ar_driver
        logic [N-1:0] hs;
        @(negedge aclk);
        hs = s_axi_arvalid & s_axi_arready;
        @(posedge aclk);
        #1;
        if (hs[0] && req_q0.size() > 0) void'(req_q0.pop_front());
        if (hs[1] && req_q1.size() > 0) void'(req_q1.pop_front());
        s_axi_arvalid[0] = (req_q0.size() > 0);
        s_axi_arvalid[1] = (req_q1.size() > 0);
        if (req_q0.size() > 0) begin
            s_axi_arid[0 +: IW] = req_q0[0].id;
            s_axi_araddr[0 +: AW] = req_q0[0].addr;
            s_axi_arlen[0 +: 8] = req_q0[0].len;
        end
        if (req_q1.size() > 0) begin
            s_axi_arid[IW +: IW] = req_q1[0].id;
            s_axi_araddr[AW +: AW] = req_q1[0].addr;
            s_axi_arlen[8 +: 8] = req_q1[0].len;
        end
    end

    // Master AR monitor.
    always begin : ar_monitor
        @(negedge aclk);
        if (aresetn && m_axi_arvalid && m_axi_arready) begin
            if (ar_exp.size() == 0) begin
                fail_msg("ar_unexpected_issue");
            end else begin
                ar_t e;
                e = ar_exp.pop_front();
                check("ar_id", DW'(m_axi_arid), DW'(e.id));
                check("ar_addr", DW'(m_axi_araddr), DW'(e.addr));
                check("ar_len", DW'(m_axi_arlen), DW'(e.len));
            end
        end
        if (aresetn && (|s_axi_arready)) begin
            check("arready_without_arvalid", DW'(s_axi_arready & ~s_axi_arvalid), '0);
        end
    end

    // Per-port R monitor.
    always begin : r_monitor
        @(negedge aclk);
        for (int p = 0; p < 2; p++) begin
            if (aresetn && s_axi_rvalid[p] && s_axi_rready[p]) begin
                if ((p == 0 && r_exp0.size() == 0) || (p == 1 && r_exp1.size() == 0)) begin
                    fail_msg("r_unexpected_beat");
                end else begin
                    r_t e;
                    e = (p == 0) ? r_exp0.pop_front() : r_exp1.pop_front();
                    check("r_id", DW'(s_axi_rid[p*IW +: IW]), DW'(e.id));
                    check("r_data", s_axi_rdata[p*DW +: DW], e.data);
                    check("r_last", DW'(s_axi_rlast[p]), DW'(e.last));
                end
            end
        end
    end

    task automatic send_beat(input logic [MIW-1:0] rid, input logic [DW-1:0] d, input logic last);
        m_axi_rid = rid; m_axi_rdata = d; m_axi_rresp = 2'b00; m_axi_rlast = last; m_axi_rvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (m_axi_rready) begin
                @(posedge aclk);
                #1;
                m_axi_rvalid = 1'b0;
                return;
            end
        end
        fail_msg("r_beat_timeout");
        m_axi_rvalid = 1'b0;
    endtask

    task automatic ret(input int unsigned port, input logic [IW-1:0] id, input logic [DW-1:0] d, input logic last);
        r_t e;
        e.id = id; e.data = d; e.last = last;
        if (port == 0) r_exp0.push_back(e); else r_exp1.push_back(e);
        send_beat({PBW'(port), id}, d, last);
    endtask

    task automatic wait_ar_drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (ar_exp.size() == 0) begin
                @(posedge aclk);
                #1;
                return;
            end
            @(negedge aclk);
        end
        fail_msg(name);
        ar_exp.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic seen;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arvalid = '0;
        s_axi_rready = '1; m_axi_arready = 1'b1;
        m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
        m3_rid = '0; m3_rlast = 1'b0; m3_rvalid = 1'b0; s3_rready = '0;

        // reset state
        tick(3);
        check("rst_arvalid", DW'(m_axi_arvalid), '0);
        check("rst_arready", DW'(s_axi_arready), '0);
        check("rst_arid", DW'(m_axi_arid), '0);
        check("rst_araddr", DW'(m_axi_araddr), '0);
        check("rst_arlen", DW'(m_axi_arlen), '0);
        check("rst_cnt0", DW'(dut.outstanding[0]), '0);
        aresetn = 1'b1;
        tick(2);

        // single port-0 request: arready at +1, master arvalid at +2
        @(negedge aclk);
        push_req(0, 8'h12, 32'h1000, 8'd3, 1'b1);
        @(posedge aclk);
        @(negedge aclk);
        check("t1_arready_c0", DW'(s_axi_arready), '0);
        @(negedge aclk);
        check("t1_arready_c1", DW'(s_axi_arready), DW'(2'b01));
        check("t1_arvalid_c1", DW'(m_axi_arvalid), '0);
        @(negedge aclk);
        check("t1_arvalid_c2", DW'(m_axi_arvalid), DW'(1'b1));
        check("t1_arid_c2", DW'(m_axi_arid), DW'(9'h012));
        @(posedge aclk);
        #1;
        check("t1_cnt_after_issue", DW'(dut.outstanding[0]), DW'(4'd1));
        for (int i = 0; i < 4; i++) ret(0, 8'h12, DW'(32'hD000_0000 + 32'(i)), (i == 3));
        tick(1);
        check("t1_cnt_after_rlast", DW'(dut.outstanding[0]), '0);

        // underflow attempt: a stray rlast to an idle port is delivered, counter stays 0
        ret(0, 8'h13, DW'(32'hBEEF), 1'b1);
        tick(1);
        check("underflow_cnt0", DW'(dut.outstanding[0]), '0);

        // both ports requesting: pointer sits at port 1 after port 0's grant
        @(negedge aclk);
        push_req(1, 8'h31, 32'h3000, 8'd0, 1'b1);
        push_req(0, 8'h21, 32'h2000, 8'd0, 1'b1);
        push_req(1, 8'h32, 32'h3100, 8'd0, 1'b1);
        push_req(0, 8'h22, 32'h2100, 8'd0, 1'b1);
        wait_ar_drain("t2_ar_timeout");
        ret(1, 8'h31, DW'(32'hA1), 1'b1);
        ret(0, 8'h21, DW'(32'hA2), 1'b1);
        ret(1, 8'h32, DW'(32'hA3), 1'b1);
        ret(0, 8'h22, DW'(32'hA4), 1'b1);
        tick(1);
        check("t2_cnt1", DW'(dut.outstanding[1]), '0);

        // outstanding cap on port 1
        @(negedge aclk);
        for (int k = 0; k < 5; k++) begin
            push_req(1, IW'(8'h40 + k), AW'(32'h4000 + 32'(k) * 32'h100), 8'd0, (k < 4));
        end
        wait_ar_drain("t3_ar_timeout");
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            if (m_axi_arvalid) seen = 1'b1;
        end
        check("t3_capped_no_issue", DW'(seen), '0);
        check("t3_cnt1_at_cap", DW'(dut.outstanding[1]), DW'(4'd4));
        @(negedge aclk);
        push_req(0, 8'h50, 32'h5000, 8'd0, 1'b1);
        wait_ar_drain("t3_port0_timeout");
        begin
            ar_t a;
            a.id = {1'b1, 8'h44}; a.addr = 32'h4400; a.len = 8'd0;
            ar_exp.push_back(a);
        end
        ret(1, 8'h40, DW'(32'hB0), 1'b1);
        wait_ar_drain("t3_fifth_timeout");
        for (int k = 1; k < 5; k++) ret(1, IW'(8'h40 + k), DW'(32'hB0 + 32'(k)), 1'b1);
        ret(0, 8'h50, DW'(32'hC0), 1'b1);
        tick(1);
        check("t3_cnt1_drained", DW'(dut.outstanding[1]), '0);
        check("t3_cnt0_drained", DW'(dut.outstanding[0]), '0);

        // R backpressure on port 1
        begin
            r_t e;
            e.id = 8'h66; e.data = {8{32'h6600_0001}}; e.last = 1'b0;
            r_exp1.push_back(e);
        end
        s_axi_rready[1] = 1'b0;
        m_axi_rid = {1'b1, 8'h66}; m_axi_rdata = {8{32'h6600_0001}}; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("t4_m_rready_low", DW'(m_axi_rready), '0);
            check("t4_rvalid_vec", DW'(s_axi_rvalid), DW'(2'b10));
            check("t4_data_held", s_axi_rdata[DW +: DW], {8{32'h6600_0001}});
        end
        check("t4_rid_stripped", DW'(s_axi_rid[0 +: IW]), DW'(8'h66));
        @(posedge aclk);
        #1;
        s_axi_rready[1] = 1'b1;
        @(negedge aclk);
        check("t4_m_rready_high", DW'(m_axi_rready), DW'(1'b1));
        @(posedge aclk);
        #1;
        m_axi_rvalid = 1'b0;

        // three-port instance: tag 3 maps to no port
        m3_rid = {2'd3, 8'h77}; m3_rlast = 1'b1; m3_rvalid = 1'b1; s3_rready = 3'b000;
        #1;
        check("t5_bad_rready", DW'(m3_rready), DW'(1'b1));
        check("t5_bad_rvalid", DW'(s3_rvalid), '0);
        tick(1);
`ifdef PICO_AXI_RD_ARB_STATS_EN
        check("t5_bad_rid_flag", DW'(rd_arb_bad_rid3), DW'(1'b1));
`endif
        m3_rid = {2'd2, 8'h77};
        #1;
        check("t5_p2_rready_low", DW'(m3_rready), '0);
        check("t5_p2_rvalid", DW'(s3_rvalid), DW'(3'b100));
        s3_rready = 3'b100;
        #1;
        check("t5_p2_rready_high", DW'(m3_rready), DW'(1'b1));
        tick(1);
        m3_rvalid = 1'b0;
        check("t5_p2_no_underflow", DW'(dut3.outstanding[2]), '0);

        // asynchronous reset while a master request is pending
        @(negedge aclk);
        push_req(1, 8'h70, 32'h7000, 8'd0, 1'b1);
        wait_ar_drain("t6_first_timeout");
        check("t6_cnt1_before_rst", DW'(dut.outstanding[1]), DW'(4'd1));
        m_axi_arready = 1'b0;
        @(negedge aclk);
        push_req(0, 8'h71, 32'h7100, 8'd0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge aclk);
            if (m_axi_arvalid) seen = 1'b1;
        end
        check("t6_issue_reached", DW'(seen), DW'(1'b1));
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            check("t6_hold_addr", DW'(m_axi_araddr), DW'(32'h7100));
            check("t6_hold_id", DW'(m_axi_arid), DW'(9'h071));
        end
        #2;
        aresetn = 1'b0;
        #1;
        check("t6_rst_arvalid", DW'(m_axi_arvalid), '0);
        check("t6_rst_cnt1", DW'(dut.outstanding[1]), '0);
        check("t6_rst_arready", DW'(s_axi_arready), '0);
        req_q0.delete();
        req_q1.delete();
        m_axi_arready = 1'b1;
        tick(2);
        aresetn = 1'b1;
        tick(3);

        check("end_ar_queue_empty", DW'(ar_exp.size()), '0);
        check("end_r0_queue_empty", DW'(r_exp0.size()), '0);
        check("end_r1_queue_empty", DW'(r_exp1.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
